// File: rtl/joy_md_pkg.sv
//------------------------------------------------------------------------------
// Module : joy_md_pkg
// Shared constants and FSM state type for the multi-port DB9 joystick reader.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package joy_md_pkg;

    // Bit positions in the 12-bit active-low MXYZ SACB RLDU word
    localparam int JB_U = 0;
    localparam int JB_D = 1;
    localparam int JB_L = 2;
    localparam int JB_R = 3;
    localparam int JB_B = 4;
    localparam int JB_C = 5;
    localparam int JB_A = 6;
    localparam int JB_S = 7;
    localparam int JB_Z = 8;
    localparam int JB_Y = 9;
    localparam int JB_X = 10;
    localparam int JB_M = 11;

    // Bit positions in the 6-bit raw pad input {C, B, R, L, D, U}
    localparam int JI_U = 0;
    localparam int JI_D = 1;
    localparam int JI_L = 2;
    localparam int JI_R = 3;
    localparam int JI_B = 4;
    localparam int JI_C = 5;

`ifdef JOY_SIXBTN_EN
    localparam int NUM_PHASES = 8;
`else
    localparam int NUM_PHASES = 4;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PHASE = 1'b1
    } joy_state_t;

endpackage

`default_nettype wire

// File: rtl/joy_md_port.sv
//------------------------------------------------------------------------------
// Module : joy_md_port
// Per-port synchroniser, shadow capture and MD/6-button detection.
// 6-button capture is present only when JOY_SIXBTN_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module joy_md_port
    import joy_md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  i_joy,
    input  logic [2:0]  i_phase,
    input  logic        i_sample,
    input  logic        i_commit,
    output logic [11:0] o_word,
    output logic        o_md,
    output logic        o_six
);

    logic [5:0]  r_meta;
    logic [5:0]  r_sync;
    logic [5:0]  r_sh_base;
    logic        r_sh_a;
    logic        r_sh_s;
    logic        r_sh_md;
    logic [11:0] r_word;
    logic        r_md;
    logic        r_six;
    logic        w_md_det;
    logic [3:0]  w_ext;
    logic        w_six;

`ifdef JOY_SIXBTN_EN
    logic        r_sh_six;
    logic [3:0]  r_sh_ext;
    assign w_ext = r_sh_ext;
    assign w_six = r_sh_six;
`else
    assign w_ext = 4'hF;
    assign w_six = 1'b0;
`endif

    // An MD pad pulls L and R low while select is low
    assign w_md_det = ~r_sync[JI_L] & ~r_sync[JI_R];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta    <= 6'h3F;
            r_sync    <= 6'h3F;
            r_sh_base <= 6'h3F;
            r_sh_a    <= 1'b1;
            r_sh_s    <= 1'b1;
            r_sh_md   <= 1'b0;
            r_word    <= 12'hFFF;
            r_md      <= 1'b0;
            r_six     <= 1'b0;
`ifdef JOY_SIXBTN_EN
            r_sh_six  <= 1'b0;
            r_sh_ext  <= 4'hF;
`endif
        end else begin
            r_meta <= i_joy;
            r_sync <= r_meta;
            if (i_sample) begin
                case (i_phase)
                    3'd0: r_sh_base <= r_sync;
                    3'd1: begin
                        r_sh_md <= w_md_det;
                        r_sh_a  <= w_md_det ? r_sync[JI_B] : 1'b1;
                        r_sh_s  <= w_md_det ? r_sync[JI_C] : 1'b1;
                    end
`ifdef JOY_SIXBTN_EN
                    3'd5: r_sh_six <= r_sh_md & (r_sync[3:0] == 4'b0000);
                    // Extra buttons arrive on the direction lines: R=M, L=X, D=Y, U=Z
                    3'd6: r_sh_ext <= r_sh_six ? {r_sync[JI_R], r_sync[JI_L],
                                                  r_sync[JI_D], r_sync[JI_U]} : 4'hF;
`endif
                    default: ;
                endcase
            end
            if (i_commit) begin
                r_word <= {w_ext, r_sh_s, r_sh_a, r_sh_base};
                r_md   <= r_sh_md;
                r_six  <= w_six;
            end
        end
    end

    assign o_word = r_word;
    assign o_md   = r_md;
    assign o_six  = r_six;

endmodule

`default_nettype wire

// File: rtl/joy_md_multi.sv
//------------------------------------------------------------------------------
// Module : joy_md_multi
// Multi-port DB9 joystick reader: shared select sequencer plus one decoder per
// port. Define JOY_SIXBTN_EN for the 8-phase 6-button sequence.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module joy_md_multi
    import joy_md_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int STEP_CYCLES = 70,
    parameter int POLL_CYCLES = 14000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6*NUM_PORTS-1:0]  joy_i,
    output logic                    joy_sel,
    output logic [12*NUM_PORTS-1:0] joy_o,
    output logic [NUM_PORTS-1:0]    sixbtn,
    output logic [NUM_PORTS-1:0]    mdpad,
    output logic                    frame_done
);

    localparam int MAX_CYC = (STEP_CYCLES > POLL_CYCLES) ? STEP_CYCLES : POLL_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] C_ONE       = CW'(1);
    localparam logic [CW-1:0] C_STEP_LOAD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] C_POLL_LOAD = CW'(POLL_CYCLES - 1);
    localparam logic [2:0]    C_LAST_PH   = 3'(NUM_PHASES - 1);

    joy_state_t    r_state, w_state_nx;
    logic [2:0]    r_phase, w_phase_nx;
    logic [CW-1:0] r_cnt,   w_cnt_nx;
    logic          r_sel,   w_sel_nx;
    logic          r_frame_done;
    logic          w_strobe;
    logic          w_commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_phase      <= 3'd0;
            r_cnt        <= '0;
            r_sel        <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_phase      <= w_phase_nx;
            r_cnt        <= w_cnt_nx;
            r_sel        <= w_sel_nx;
            r_frame_done <= w_commit;
        end
    end

    // Count 0 marks the first cycle of a state and triggers the reload;
    // the state then ends on the cycle where the count reaches 1.
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_cnt_nx   = r_cnt;
        w_sel_nx   = r_sel;
        w_strobe   = 1'b0;
        w_commit   = 1'b0;
        if (r_cnt == '0) begin
            w_cnt_nx = (r_state == ST_IDLE) ? C_POLL_LOAD : C_STEP_LOAD;
        end else if (r_cnt != C_ONE) begin
            w_cnt_nx = r_cnt - C_ONE;
        end else begin
            w_cnt_nx = '0;
            if (r_state == ST_IDLE) begin
                w_state_nx = ST_PHASE;
                w_phase_nx = 3'd0;
                w_sel_nx   = 1'b1;
            end else begin
                w_strobe = 1'b1;
                if (r_phase == C_LAST_PH) begin
                    w_commit   = 1'b1;
                    w_state_nx = ST_IDLE;
                    w_phase_nx = 3'd0;
                    w_sel_nx   = 1'b1;
                end else begin
                    w_phase_nx = r_phase + 3'd1;
                    // Next phase is even (select high) when the current one is odd
                    w_sel_nx   = r_phase[0];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        joy_md_port u_port (
            .clk      (clk),
            .reset    (reset),
            .i_joy    (joy_i[6*p +: 6]),
            .i_phase  (r_phase),
            .i_sample (w_strobe),
            .i_commit (w_commit),
            .o_word   (joy_o[12*p +: 12]),
            .o_md     (mdpad[p]),
            .o_six    (sixbtn[p])
        );
    end

    assign joy_sel    = r_sel;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_joy_md_multi.sv
//------------------------------------------------------------------------------
// Module : tb_joy_md_multi
// Self-checking bench for joy_md_multi with behavioural Atari/MD3/MD6 pads.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_joy_md_multi;

    localparam int STEP  = 6;
    localparam int POLL  = 20;
`ifdef JOY_SIXBTN_EN
    localparam int PH    = 8;
    localparam bit SIX   = 1'b1;
`else
    localparam int PH    = 4;
    localparam bit SIX   = 1'b0;
`endif
    localparam int FRAME = POLL + PH * STEP;

    typedef struct {
        logic [23:0] jo;
        logic [1:0]  md;
        logic [1:0]  six;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] joy_i;
    logic        joy_sel;
    logic [23:0] joy_o;
    logic [1:0]  sixbtn;
    logic [1:0]  mdpad;
    logic        frame_done;

    int          typ [2];
    logic [11:0] pr  [2];
    int          low_idx = 0;
    int          hi_cnt  = 0;
    logic        prev_sel = 1'b1;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    joy_md_multi #(
        .NUM_PORTS   (2),
        .STEP_CYCLES (STEP),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .joy_i      (joy_i),
        .joy_sel    (joy_sel),
        .joy_o      (joy_o),
        .sixbtn     (sixbtn),
        .mdpad      (mdpad),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Pad-side select tracking: count low pulses, reset after a long high
    always @(posedge clk) begin
        prev_sel <= joy_sel;
        if (prev_sel && !joy_sel) low_idx <= low_idx + 1;
        if (joy_sel) begin
            hi_cnt <= hi_cnt + 1;
            if (hi_cnt > 2 * STEP) low_idx <= 0;
        end else begin
            hi_cnt <= 0;
        end
    end

    // typ: 0 empty, 1 Atari, 2 MD 3-button, 3 MD 6-button; pr: pressed (1) per word bit
    function automatic logic [5:0] pad_lines(input int t, input logic [11:0] p,
                                             input logic sel, input int idx);
        logic [11:0] n;
        logic [5:0]  r;
        n = ~p;
        if (t == 0)                 r = 6'h3F;
        else if (t == 1)            r = n[5:0];
        else if (t == 3 && idx == 3)
            r = sel ? {n[5], n[4], n[11], n[10], n[9], n[8]} : {n[7], n[6], 4'b0000};
        else
            r = sel ? n[5:0] : {n[7], n[6], 2'b00, n[1], n[0]};
        return r;
    endfunction

    always_comb begin
        joy_i = {pad_lines(typ[1], pr[1], joy_sel, low_idx),
                 pad_lines(typ[0], pr[0], joy_sel, low_idx)};
    end

    function automatic logic [11:0] exp_word(input int t, input logic [11:0] p);
        logic [11:0] w;
        case (t)
            1:       w = ~(p & 12'h03F);
            2:       w = ~(p & 12'h0FF);
            3:       w = SIX ? ~p : ~(p & 12'h0FF);
            default: w = 12'hFFF;
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input int t0, input logic [11:0] p0, input int t1, input logic [11:0] p1);
        exp_t e;
        typ[0] = t0; pr[0] = p0;
        typ[1] = t1; pr[1] = p1;
        e.jo  = {exp_word(t1, p1), exp_word(t0, p0)};
        e.md  = {1'(t1 >= 2), 1'(t0 >= 2)};
        e.six = {1'(SIX && t1 == 3), 1'(SIX && t0 == 3)};
        sb.push_back(e);
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!frame_done && n < 3 * FRAME);
    endtask

    task automatic frame_check(input string tag);
        int   n;
        exp_t e;
        wait_fd(n);
        chk({tag, "_period"}, n, FRAME);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_joy_o"},  joy_o,  e.jo);
            chk({tag, "_mdpad"},  mdpad,  e.md);
            chk({tag, "_sixbtn"}, sixbtn, e.six);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_joy_o"},  joy_o,      24'hFFFFFF);
        chk({tag, "_sixbtn"}, sixbtn,     2'b00);
        chk({tag, "_mdpad"},  mdpad,      2'b00);
        chk({tag, "_fdone"},  frame_done, 1'b0);
        chk({tag, "_sel"},    joy_sel,    1'b1);
    endtask

    initial begin
        bit early;
        typ[0] = 0; typ[1] = 0; pr[0] = '0; pr[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;

        // First frame: select pattern and frame_done timing
        early = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(posedge clk); #1;
            if (k < FRAME && frame_done) early = 1'b1;
            if (k == POLL - 1) chk("idle_sel", joy_sel, 1'b1);
            for (int p = 0; p < PH; p++)
                if (k == POLL + p * STEP + 2) chk($sformatf("sel_ph%0d", p), joy_sel, 1'(~p[0]));
        end
        chk("first_fd", frame_done, 1'b1);
        chk("early_fd", early, 1'b0);
        chk("empty_joy_o", joy_o, 24'hFFFFFF);
        chk("empty_md", mdpad, 2'b00);
        chk("empty_six", sixbtn, 2'b00);

        apply(1, 12'h011, 0, 12'h000);   // Atari Up+B on port 0
        frame_check("atari");
        apply(0, 12'h000, 2, 12'h088);   // MD3 Start+Right on port 1
        frame_check("md3");
        apply(3, 12'hC40, 0, 12'h000);   // MD6 Mode+X+A on port 0
        frame_check("md6");
        apply(3, 12'h410, 2, 12'h020);   // MD6 X+B on port 0, MD3 C on port 1
        frame_check("md6xb");
        apply(3, 12'h100, 2, 12'h020);   // MD6 Z on port 0
        frame_check("md6z");

        // Reset in the middle of the late select phases
        repeat (POLL + (PH - 2) * STEP + 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        reset = 1'b0;
        apply(3, 12'h100, 2, 12'h020);
        frame_check("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/joy_md_multi.md
# joy_md_multi

Parametrised multi-port DB9 joystick reader. Drives one shared select line and decodes Atari-style 1/2-button, Mega Drive 3-button and Mega Drive 6-button pads on `NUM_PORTS` ports. It presents each port in the 12-bit active-low `MXYZ SACB RLDU` word consumed by the message/updater logic. It sits between the board's raw joystick pins and every consumer of `joyN_o`, replacing per-port fixed 6-button readers.

## Interface

Parameters:
- `NUM_PORTS`, default 2: number of DB9 ports, 1..8.
- `STEP_CYCLES`, default 70: clock cycles per select phase (10 µs at 7 MHz); minimum 4.
- `POLL_CYCLES`, default 14000: idle cycles between frames with select held high (2 ms at 7 MHz); minimum 4.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `joy_i`, in, 6*NUM_PORTS: raw pad lines, active-low, asynchronous. Per port p, bits [6p+5:6p] = {C, B, R, L, D, U}.
- `joy_sel`, out, 1: select line shared by all ports.
- `joy_o`, out, 12*NUM_PORTS: decoded buttons, active-low. Per port p, bits [12p+11:12p] = M X Y Z S A C B R L D U.
- `sixbtn`, out, NUM_PORTS: 1 = last frame detected a 6-button pad on that port.
- `mdpad`, out, NUM_PORTS: 1 = last frame detected a Mega Drive pad (3- or 6-button).
- `frame_done`, out, 1: one-cycle pulse when `joy_o`, `sixbtn` and `mdpad` update.

## Operation

- Every `joy_i` bit passes through a 2-flop synchroniser. The flops reset to 1.
- FSM states:
  - IDLE: `joy_sel`=1 for `POLL_CYCLES` cycles.
  - PHASE: phases 0..7, each `STEP_CYCLES` cycles. `joy_sel` = 1 on even phases, 0 on odd phases.
  - After phase 7 the FSM returns to IDLE.
- Sampling happens on the last cycle of each phase, into per-port shadow registers. Synchronised lines (active-low) are captured as follows:
  - Phase 0: U, D, L, R, B, C.
  - Phase 1: if L=0 and R=0, set the MD flag and capture A←B line, S←C line. Otherwise A=S=1 and MD=0.
  - Phase 5: if MD and U=D=L=R=0, set the six flag.
  - Phase 6: if six, capture Z←U, Y←D, X←L, M←R. Otherwise M, X, Y, Z = 1.
  - Phases 2, 3, 4 and 7 are not sampled.
- Commit: on the edge that ends phase 7, all ports' shadow registers load into `joy_o`, `mdpad` and `sixbtn` in the same cycle (atomic across ports). `frame_done` is 1 for exactly the following cycle.
- Non-MD pad: only U, D, L, R, B, C are reported; A, S, M, X, Y, Z read released (1).
- Empty port (all lines pulled high): all 12 bits are 1, `mdpad`=0, `sixbtn`=0.
- Ports are decoded independently. A 6-button pad on one port never affects another port.

## Timing

- Reset values: `joy_o` all 1, `sixbtn`=0, `mdpad`=0, `frame_done`=0, `joy_sel`=1, FSM in IDLE with counter 0.
- Frame period is exactly `POLL_CYCLES + 8*STEP_CYCLES` cycles. The first `frame_done` occurs `POLL_CYCLES + 8*STEP_CYCLES` cycles after `reset` deasserts.
- Input-to-output latency: 2 synchroniser cycles, plus the wait to the next sample point, plus the wait to the next commit.
- `joy_sel` is registered. It changes on the first cycle of each phase. Because of synchroniser delay, a sample taken in the last cycle of a phase sees pins that have settled for at least `STEP_CYCLES`-3 cycles.
- Reset asserted mid-frame: the frame is abandoned, shadow registers are discarded, and all outputs return to reset values on the next edge. There is no partial commit.
- Counter width is `$clog2(max(STEP_CYCLES, POLL_CYCLES))`. Counters count down and reload with no wrap beyond the loaded value.

## Configuration

- `JOY_SIXBTN_EN` defined: the full 8-phase sequence, 6-button detection and M/X/Y/Z capture.
- `JOY_SIXBTN_EN` undefined:
  - The sequence is phases 0..3 only, so the frame period is `POLL_CYCLES + 4*STEP_CYCLES`.
  - `sixbtn` is tied to 0.
  - M, X, Y, Z are always 1.
  - 3-button MD and Atari decoding are unchanged.

## Structure

- Package `joy_md_pkg`:
  - Bit-index constants for the 12-bit word (`JB_U`=0, `JB_D`=1, `JB_L`=2, `JB_R`=3, `JB_B`=4, `JB_C`=5, `JB_A`=6, `JB_S`=7, `JB_Z`=8, `JB_Y`=9, `JB_X`=10, `JB_M`=11).
  - Bit indices for the 6-bit raw input.
  - The FSM state enum.
- Sub-module `joy_md_port`: one per port, generated. It contains the synchroniser, shadow registers and the MD/six flags. It takes `phase`, `sample_strobe` and `commit` from the shared sequencer in `joy_md_multi`.

## Test plan

- Reset release with all `joy_i`=1: `joy_sel` pattern 1,0,1,0,1,0,1,0 per phase. First `frame_done` at cycle `POLL_CYCLES+8*STEP_CYCLES`. `joy_o`=0xFFF per port, `mdpad`=`sixbtn`=0.
- Atari pad on port 0 holding Up+B (U=0, B=0 constant): `joy_o[11:0]`=0xFEE, `mdpad[0]`=0.
- 3-button MD model on port 1 pressing Start+Right: `joy_o[23:12]`=0xF77, `mdpad[1]`=1, `sixbtn[1]`=0.
- 6-button MD model on port 0 pressing Mode+X+A: `joy_o[11:0]`=0x3BF, `sixbtn[0]`=1. Port 1 empty stays 0xFFF.
- Reset asserted during phase 6 with a 6-button pad pressing Z: outputs return to reset values next cycle. No `frame_done` occurs until a full frame after release.
- Build without `JOY_SIXBTN_EN`, 6-button pad pressing X+B: `joy_o`=0xFEF, `sixbtn`=0, frame period `POLL_CYCLES+4*STEP_CYCLES`.
